line_mem: RTL and testbench
===========================

Name: line_mem

Overview:
- Parametrised main-memory model serving full cache lines to the cache controller.
- Successor of the fixed 64-byte, read-only, fixed-delay RAM model.
- Adds line writes (write-back), separate read and write latencies, a real backing store with deterministic fill for unwritten lines, out-of-range error reporting, and valid/ready handshakes on both request and response.
- Holds one outstanding transaction at a time.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_BYTES, 64, line size in bytes; power of two, at least 4.
- DEPTH_LINES, 1024, number of lines in the backing store.
- READ_LAT, 100, cycles from read acceptance to rsp_valid; at least 1.
- WRITE_LAT, 100, cycles from write acceptance to rsp_valid; at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = line write, 0 = line read.
- req_addr  in  ADDR_W  byte address; low log2(LINE_BYTES) bits ignored.
- req_wdata  in  LINE_BYTES*8  write line data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_we  out  1  echo of req_we for this response.
- rsp_err  out  1  address out of range.
- rsp_rdata  out  LINE_BYTES*8  read data; 0 for writes and errors.

Behaviour:
- Reset (asynchronous, rst high):
  - State goes to IDLE.
  - Outputs reset values: req_ready=0 while rst is high, then 1 in IDLE; rsp_valid=0, rsp_we=0, rsp_err=0, rsp_rdata=0.
  - Per-line written flags cleared; storage array itself is not reset.
  - Latency counter cleared.
- Line index:
  - idx = req_addr >> log2(LINE_BYTES).
  - Error condition: idx >= DEPTH_LINES.
- States:
  - IDLE, WAIT, RESP.
  - req_ready is 1 only in IDLE.
- IDLE:
  - On req_valid and req_ready at a rising edge: latch we, idx and wdata (acceptance edge A).
  - Load the counter with READ_LAT-1 or WRITE_LAT-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP and drive the response registers.
  - rsp_valid rises at edge A+LAT exactly, where LAT is the selected latency.
- Read response data:
  - If the line's written flag is set: rsp_rdata = stored line.
  - Otherwise, fill pattern: byte b = (idx[7:0] + b) mod 256, byte 0 in bits [7:0].
- Write completion:
  - Store wdata and set the written flag at the RESP entry edge, not at acceptance.
  - rsp_rdata = 0.
- Errors:
  - Full latency still applies.
  - rsp_err=1, rsp_rdata=0, storage and flags unchanged.
- RESP:
  - rsp_valid, rsp_we, rsp_err and rsp_rdata are held stable until rsp_ready is high at an edge.
  - That edge returns the block to IDLE with rsp_valid=0 and the response fields cleared.
  - No bypass: a new request is accepted at the earliest one cycle after the response handshake.
  - Minimum request-to-request spacing is therefore LAT+2 cycles with rsp_ready held high.
- Handshake rules:
  - req_valid while not ready is ignored.
  - Requester must hold req_* stable until accepted.
  - req_* may change freely after acceptance without affecting the in-flight transaction.
- Reset mid-operation:
  - Abandons the transaction immediately; a pending write is not committed.
  - Returns to IDLE; any flags set before reset are cleared.
- Counter width: $clog2(max(READ_LAT, WRITE_LAT)+1) bits; no wrap-around is possible.

Test Plan:
- Reset, then read addr 0x0000_0040 (idx 1) with READ_LAT=100 -> rsp_valid at exactly edge A+100; byte0=0x01, byte63=0x40; rsp_err=0, rsp_we=0.
- Write addr 0x80 with data all 0xA5, WRITE_LAT=100 -> rsp_valid at A+100 with rsp_we=1, rdata=0; following read of 0x80 returns all 0xA5; read of 0xBF (same line, offset bits ignored) returns all 0xA5.
- Read addr DEPTH_LINES*LINE_BYTES (0x10000 for defaults) -> rsp_err=1, rdata=0 at A+100; a write to the same address also sets rsp_err=1, and a later in-range read is unaffected.
- Back-pressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> response fields stable throughout; req_ready=0 and a concurrent req_valid is not accepted; release -> IDLE next cycle.
- Reset asserted at cycle 50 of a write to 0x80 -> rsp_valid never rises; after reset, read 0x80 returns fill pattern byte0=0x02; a previously written line also returns fill pattern.
- Parameter sweep LINE_BYTES=32, DEPTH_LINES=16, READ_LAT=1, WRITE_LAT=3 -> read rsp at A+1, write rsp at A+3; idx 16 flags error; back-to-back reads spaced 3 cycles with rsp_ready high.

Source files
------------

// File: rtl/line_mem.sv
// line_mem: main-memory model serving whole cache lines, one transaction at a time.
// Reads and writes complete after a fixed per-kind latency. Lines that were never
// written read back a deterministic fill pattern. Out-of-range lines report rsp_err.
module line_mem #(
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = 64,
  parameter int DEPTH_LINES = 1024,
  parameter int READ_LAT    = 100,
  parameter int WRITE_LAT   = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic                    rsp_err,
  output logic [LINE_BYTES*8-1:0] rsp_rdata
);
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int LINE_W  = LINE_BYTES * 8;
  localparam int IDXF_W  = ADDR_W - OFF_W;
  localparam int IDX_W   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // In-flight request, captured at acceptance so req_* may change afterwards.
  typedef struct packed {
    logic             we;
    logic             err;
    logic [IDX_W-1:0] idx;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_t                 state;
  req_t                   cur;
  logic [CNT_W-1:0]       cnt;
  logic [LINE_W-1:0]      mem [DEPTH_LINES];
  logic [DEPTH_LINES-1:0] written;

  logic [IDXF_W-1:0] idx_in;
  logic              idx_err;
  logic [LINE_W-1:0] fill;
  logic [LINE_W-1:0] rd_line;
  logic              done;
  logic              unused_ok;

  assign idx_in    = req_addr[ADDR_W-1:OFF_W];
  assign idx_err   = {1'b0, idx_in} >= (IDXF_W+1)'(DEPTH_LINES);
  assign unused_ok = ^req_addr[OFF_W-1:0];
  assign req_ready = (state == IDLE) && !rst;
  assign done      = (state == WAIT) && (cnt == '0);
  assign rd_line   = written[cur.idx] ? mem[cur.idx] : fill;

  // Fill pattern for unwritten lines: byte b = idx[7:0] + b.
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_fill
    assign fill[b*8 +: 8] = 8'(cur.idx) + 8'(b);
  end

  // Transaction FSM: accept, count down the latency, present and hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      written   <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cur.we    <= req_we;
          cur.err   <= idx_err;
          cur.idx   <= idx_in[IDX_W-1:0];
          cur.wdata <= req_wdata;
          cnt       <= req_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
          state     <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_we    <= cur.we;
          rsp_err   <= cur.err;
          rsp_rdata <= (cur.we || cur.err) ? '0 : rd_line;
          if (cur.we && !cur.err) written[cur.idx] <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_we    <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store; a write commits only on the RESP entry edge (reset holds state in IDLE).
  always_ff @(posedge clk) begin
    if (done && cur.we && !cur.err) mem[cur.idx] <= cur.wdata;
  end
endmodule

// File: tb/tb_line_mem.sv
// Scoreboard bench for line_mem: default instance (64B lines, 100-cycle latencies)
// and a small instance (32B lines, 16 lines, read 1 / write 3 cycles).
module tb_line_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic         req_valid0 = 0, req_we0 = 0, rsp_ready0 = 1;
  logic [31:0]  req_addr0 = 0;
  logic [511:0] req_wdata0 = 0;
  logic         req_ready0, rsp_valid0, rsp_we0, rsp_err0;
  logic [511:0] rsp_rdata0;

  // Small instance
  logic         req_valid1 = 0, req_we1 = 0, rsp_ready1 = 1;
  logic [31:0]  req_addr1 = 0;
  logic [255:0] req_wdata1 = 0;
  logic         req_ready1, rsp_valid1, rsp_we1, rsp_err1;
  logic [255:0] rsp_rdata1;

  line_mem dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_we(rsp_we0), .rsp_err(rsp_err0), .rsp_rdata(rsp_rdata0));

  line_mem #(.ADDR_W(32), .LINE_BYTES(32), .DEPTH_LINES(16), .READ_LAT(1), .WRITE_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_we(rsp_we1), .rsp_err(rsp_err1), .rsp_rdata(rsp_rdata1));

  typedef struct {
    logic         we;
    logic         err;
    logic [511:0] data;
    int           cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  function automatic void chkd(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0b exp=%0b", nm, act, exp);
    end
  endfunction

  function automatic void chki(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endfunction

  function automatic logic [511:0] fill(int idx, int nb);
    logic [511:0] r = '0;
    for (int b = 0; b < nb; b++) r[b*8 +: 8] = 8'(idx + b);
    return r;
  endfunction

  // Issue one request on instance d; queue the expected response when push is set.
  task automatic issue(input bit d, input bit we, input logic [31:0] addr, input logic [511:0] wd,
                       input bit push, input bit eerr, input logic [511:0] ed, output int acc);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    if (!d) begin
      req_valid0 = 1; req_we0 = we; req_addr0 = addr; req_wdata0 = wd;
    end else begin
      req_valid1 = 1; req_we1 = we; req_addr1 = addr; req_wdata1 = wd[255:0];
    end
    while (((d ? req_ready1 : req_ready0) !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (n >= 400) begin
      chki("issue_timeout", n, 0);
    end else begin
      acc = cyc + 1;
      if (push) begin
        e.we = we; e.err = eerr; e.data = ed;
        e.cyc = acc + (d ? (we ? 3 : 1) : 100);
        if (!d) q0.push_back(e); else q1.push_back(e);
      end
      @(negedge clk);
    end
    // Scramble request fields after acceptance; the in-flight transaction must not care.
    if (!d) begin
      req_valid0 = 0; req_addr0 = ~addr; req_wdata0 = ~wd; req_we0 = ~we;
    end else begin
      req_valid1 = 0; req_addr1 = ~addr; req_wdata1 = ~wd[255:0]; req_we1 = ~we;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rsp_valid0 || rsp_valid1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chki("drain_timeout", n, 0);
  endtask

  // Monitor for the default instance: compares each new response, then checks it holds.
  initial begin
    logic pv = 0, cw = 0, ce = 0;
    logic [511:0] cd = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid0 && !pv) begin
        if (q0.size() == 0) begin
          chk1("m0_unexpected_rsp", rsp_valid0, 1'b0);
        end else begin
          e = q0.pop_front();
          chki("m0_latency", cyc, e.cyc);
          chk1("m0_we", rsp_we0, e.we);
          chk1("m0_err", rsp_err0, e.err);
          chkd("m0_rdata", rsp_rdata0, e.data);
        end
        cw = rsp_we0; ce = rsp_err0; cd = rsp_rdata0;
      end else if (rsp_valid0 && pv) begin
        chk1("m0_hold_we", rsp_we0, cw);
        chk1("m0_hold_err", rsp_err0, ce);
        chkd("m0_hold_rdata", rsp_rdata0, cd);
      end
      pv = rsp_valid0;
    end
  end

  // Monitor for the small instance.
  initial begin
    logic pv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid1 && !pv) begin
        if (q1.size() == 0) begin
          chk1("m1_unexpected_rsp", rsp_valid1, 1'b0);
        end else begin
          e = q1.pop_front();
          chki("m1_latency", cyc, e.cyc);
          chk1("m1_we", rsp_we1, e.we);
          chk1("m1_err", rsp_err1, e.err);
          chkd("m1_rdata", {256'b0, rsp_rdata1}, e.data);
        end
      end
      pv = rsp_valid1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a, a2, n;
    logic seen;
    logic [511:0] a5 = {64{8'hA5}};
    logic [511:0] dw1 = {256'b0, {8{32'hDEADBEEF}}};

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_req_ready", req_ready0, 1'b0);
    chk1("rst_rsp_valid", rsp_valid0, 1'b0);
    chk1("rst_rsp_err", rsp_err0, 1'b0);
    chkd("rst_rsp_rdata", rsp_rdata0, '0);
    rst = 0;
    @(negedge clk);
    chk1("idle_req_ready", req_ready0, 1'b1);

    // Fill pattern read, line write, read-back, offset bits ignored
    issue(0, 0, 32'h40, '0, 1, 0, fill(1, 64), a);
    drain();
    issue(0, 1, 32'h80, a5, 1, 0, '0, a);
    drain();
    issue(0, 0, 32'h80, '0, 1, 0, a5, a);
    drain();
    issue(0, 0, 32'hBF, '0, 1, 0, a5, a);
    drain();

    // Out-of-range read and write; an aliased in-range line stays untouched
    issue(0, 0, 32'h10000, '0, 1, 1, '0, a);
    drain();
    issue(0, 1, 32'h10000, a5, 1, 1, '0, a);
    drain();
    issue(0, 0, 32'h0, '0, 1, 0, fill(0, 64), a);
    drain();

    // Back-pressure: response held, competing request ignored
    rsp_ready0 = 0;
    issue(0, 0, 32'h100, '0, 1, 0, fill(4, 64), a);
    n = 0;
    while (!rsp_valid0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chki("bp_rsp_timeout", n, 0);
    for (int i = 0; i < 20; i++) begin
      req_valid0 = 1; req_we0 = 0; req_addr0 = 32'h140;
      chk1("bp_req_ready", req_ready0, 1'b0);
      @(negedge clk);
    end
    req_valid0 = 0;
    rsp_ready0 = 1;
    @(negedge clk);
    chk1("bp_release_valid", rsp_valid0, 1'b0);
    chk1("bp_release_ready", req_ready0, 1'b1);
    drain();

    // Reset in the middle of a write to a previously written line
    issue(0, 1, 32'h80, {64{8'h5A}}, 0, 0, '0, a);
    repeat (48) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk1("midrst_req_ready", req_ready0, 1'b0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (rsp_valid0) seen = 1;
    end
    chk1("midrst_no_rsp", seen, 1'b0);
    issue(0, 0, 32'h80, '0, 1, 0, fill(2, 64), a);
    drain();

    // Small instance: short latencies, error boundary, back-to-back spacing
    issue(1, 0, 32'h20, '0, 1, 0, fill(1, 32), a);
    drain();
    issue(1, 1, 32'h40, dw1, 1, 0, '0, a);
    drain();
    issue(1, 0, 32'h40, '0, 1, 0, dw1, a);
    drain();
    issue(1, 0, 32'h200, '0, 1, 1, '0, a);
    drain();
    issue(1, 0, 32'h0, '0, 1, 0, fill(0, 32), a);
    issue(1, 0, 32'h20, '0, 1, 0, fill(1, 32), a2);
    chki("b2b_spacing", a2 - a, 3);
    drain();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
